activation_read_sequencer: RTL and testbench

// - Drain side of the activation unit's buffer: read side paired with the write-address up counter.
// - On start, walks LENGTH consecutive words from base_addr using a loadable down counter of remaining reads.
// - Issues synchronous memory reads and streams the returned data out on a valid/ready interface, marking the last beat.
// - Never overruns the downstream stage: the number of issued reads is credit-limited to the internal buffer space.

---
 rtl/activation_read_sequencer_pkg.sv | 19 +
 rtl/act_rd_skid_fifo.sv | 62 ++++++
 rtl/activation_read_sequencer.sv | 138 +++++++++++++
 tb/tb_activation_read_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_read_sequencer_pkg.sv
// Shared definitions for the activation read sequencer.
//   seq_state_t : sequencer FSM encoding (IDLE, RUN, DRAIN, FINISH)
//   skid_depth  : output buffer depth for a given memory read latency. One
//                 slot per in-flight read plus one more, so the read stream
//                 runs at full rate while the downstream stage keeps up.
package activation_read_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } seq_state_t;

    function automatic int skid_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

endpackage

// File: rtl/act_rd_skid_fifo.sv
// Small synchronous FIFO that sits between the memory return path and the
// valid/ready output. Pushing and popping in the same cycle is legal and
// leaves the count unchanged. The caller never pushes when full and never
// pops when empty.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push         : write push_data at the tail
//   push_data    : entry to write
//   pop          : drop the head entry
//   head_data    : current head entry, meaningful only while count != 0
//   count        : number of stored entries, 0..DEPTH
module act_rd_skid_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: storage is not reset; count alone decides whether an entry is
    // valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clock) begin
        if (push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = storage[rd_ptr];

endmodule

// File: rtl/activation_read_sequencer.sv
// Drain side of the activation buffer. On start, reads `length` consecutive
// words from base_addr (wrapping modulo 2^ADDR_WIDTH) and streams them out on
// a valid/ready interface, flagging the final beat with out_last. Reads are
// credit-limited so that issued-but-unconsumed words never exceed the skid
// buffer capacity.
// Ports:
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   start, base_addr, length  : transfer request, sampled only while idle
//   busy, done                : busy from the cycle after start through done;
//                               done is a 1-cycle completion pulse
//   mem_rd_en, mem_rd_addr    : read strobe and address to the buffer memory
//   mem_rd_data               : read data, RD_LATENCY cycles after the strobe
//   out_valid, out_data,
//   out_last, out_ready       : output stream
module activation_read_sequencer
    import activation_read_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int DEPTH = skid_depth(RD_LATENCY);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0]         DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH + 1)'(1);

    seq_state_t state, next_state;

    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_last;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CW:0]           occupied;
    logic                  issue;
    logic                  pop;
    logic                  ret;

    // A beat leaving this cycle frees its slot in time for a read issued now,
    // which is what sustains one beat per cycle with the minimum depth.
    assign occupied = {1'b0, fifo_count} + {1'b0, inflight};
    assign pop      = out_valid & out_ready;
    assign ret      = pipe_valid[RD_LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) next_state = (length == '0) ? ST_FINISH : ST_RUN;
            end
            ST_RUN: begin
                issue = (remaining != '0) && (occupied < DEPTH_W + {{CW{1'b0}}, pop});
                if (issue && remaining == REM_ONE) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && out_last) next_state = ST_FINISH;
            end
            ST_FINISH: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Down counter of remaining reads, address counter, and the latency pipe
    // that tags each issued read with valid/last until its data returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining  <= '0;
            addr       <= '0;
            pipe_valid <= '0;
            pipe_last  <= '0;
            inflight   <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                remaining <= length;
                addr      <= base_addr;
            end else if (issue) begin
                remaining <= remaining - 1'b1;
                addr      <= addr + 1'b1;
            end
            pipe_valid <= RD_LATENCY'({pipe_valid, issue});
            pipe_last  <= RD_LATENCY'({pipe_last, issue && remaining == REM_ONE});
            inflight   <= inflight + CW'(issue) - CW'(ret);
        end
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr;

    act_rd_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (ret),
        .push_data ({pipe_last[RD_LATENCY-1], mem_rd_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // Head contents are masked while empty so the idle output is all zeros.
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign out_last  = out_valid & fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_activation_read_sequencer.sv
// Directed testbench for activation_read_sequencer (ADDR_WIDTH=6,
// DATA_WIDTH=16, RD_LATENCY=1, so the skid depth is 2). A behavioural memory
// returns a distinct word per address; a negedge monitor logs reads, accepted
// beats and done pulses with their cycle numbers for the scenario tasks.
module tb_activation_read_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  length;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [5:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [5:0]  rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [15:0] beat_data_q[$];
    logic        beat_last_q[$];
    int          beat_cyc_q[$];
    int          done_cyc_q[$];

    activation_read_sequencer #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (16),
        .RD_LATENCY (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] word_at(input logic [5:0] a);
        return {4'hC, a, ~a};
    endfunction

    // One-cycle-latency memory; returns a marker word when not strobed.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        mem_rd_data <= mem_rd_en ? word_at(mem_rd_addr) : 16'hDEAD;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_rd_en) begin
                rd_addr_q.push_back(mem_rd_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                beat_data_q.push_back(out_data);
                beat_last_q.push_back(out_last);
                beat_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        beat_data_q.delete();
        beat_last_q.delete();
        beat_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic pulse_start(input logic [5:0] b, input logic [6:0] l, output int s);
        s         = cyc;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        base_addr = 6'h3F;
        length    = 7'd9;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cyc_q.size() == 0; i++) tick(1);
        n_vec++;
        if (done_cyc_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        tick(2);
    endtask

    // Compares the logged transfer against `len` sequential reads from `b`.
    task automatic expect_transfer(input string name, input logic [5:0] b, input int len);
        int bad_addr = 0;
        int bad_data = 0;
        int bad_last = 0;
        n_vec++;
        if (rd_addr_q.size() != len) begin
            n_err++;
            $display("FAIL %s_nreads: got %0d want %0d", name, rd_addr_q.size(), len);
        end
        n_vec++;
        if (beat_data_q.size() != len) begin
            n_err++;
            $display("FAIL %s_nbeats: got %0d want %0d", name, beat_data_q.size(), len);
        end
        for (int i = 0; i < len; i++) begin
            logic [5:0] a;
            a = b + 6'(i);
            if (i < rd_addr_q.size() && rd_addr_q[i] !== a) bad_addr++;
            if (i < beat_data_q.size()) begin
                if (beat_data_q[i] !== word_at(a)) bad_data++;
                if (beat_last_q[i] !== (i == len - 1)) bad_last++;
            end
        end
        n_vec++;
        if (bad_addr != 0) begin
            n_err++;
            $display("FAIL %s_addr: %0d wrong read addresses, want 0", name, bad_addr);
        end
        n_vec++;
        if (bad_data != 0) begin
            n_err++;
            $display("FAIL %s_data: %0d wrong beat words, want 0", name, bad_data);
        end
        n_vec++;
        if (bad_last != 0) begin
            n_err++;
            $display("FAIL %s_last: %0d wrong out_last flags, want 0", name, bad_last);
        end
        n_vec++;
        if (done_cyc_q.size() != 1) begin
            n_err++;
            $display("FAIL %s_ndone: got %0d done pulses want 1", name, done_cyc_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [26:0] obs;
        @(negedge clock);
        obs = {busy, done, mem_rd_en, mem_rd_addr, out_valid, out_last, out_data};
        n_vec++;
        if (obs !== 27'd0) begin
            n_err++;
            $display("FAIL %s: outputs got %h want 0", name, obs);
        end
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int s;
        out_ready = 1'b1;
        clear_logs();
        pulse_start(6'd5, 7'd4, s);
        wait_done("basic", 30);
        expect_transfer("basic", 6'd5, 4);
        for (int i = 0; i < 4 && i < rd_cyc_q.size(); i++) begin
            n_vec++;
            if (rd_cyc_q[i] != s + 1 + i) begin
                n_err++;
                $display("FAIL basic_rd_cyc%0d: got %0d want %0d", i, rd_cyc_q[i] - s, 1 + i);
            end
        end
        for (int i = 0; i < 4 && i < beat_cyc_q.size(); i++) begin
            n_vec++;
            if (beat_cyc_q[i] != s + 3 + i) begin
                n_err++;
                $display("FAIL basic_beat_cyc%0d: got %0d want %0d", i, beat_cyc_q[i] - s, 3 + i);
            end
        end
        if (done_cyc_q.size() > 0) begin
            n_vec++;
            if (done_cyc_q[0] != s + 7) begin
                n_err++;
                $display("FAIL basic_done_cyc: got %0d want 7", done_cyc_q[0] - s);
            end
        end
    endtask

    task automatic test_wrap();
        int s;
        clear_logs();
        pulse_start(6'd62, 7'd4, s);
        wait_done("wrap", 30);
        expect_transfer("wrap", 6'd62, 4);
    endtask

    task automatic test_stall();
        int s;
        int bad = 0;
        out_ready = 1'b0;
        clear_logs();
        pulse_start(6'd10, 7'd3, s);
        // Cycles s+1 .. s+10 with out_ready low.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c >= 3 && (out_valid !== 1'b1 || out_data !== word_at(6'd10) || out_last !== 1'b0))
                bad++;
            tick(1);
        end
        n_vec++;
        if (rd_addr_q.size() != 2) begin
            n_err++;
            $display("FAIL stall_reads: got %0d want 2", rd_addr_q.size());
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_hold: %0d stalled cycles unstable, want 0", bad);
        end
        out_ready = 1'b1;
        wait_done("stall", 30);
        expect_transfer("stall", 6'd10, 3);
    endtask

    task automatic test_zero_length();
        int s;
        clear_logs();
        pulse_start(6'd7, 7'd0, s);
        @(negedge clock);
        n_vec++;
        if ({busy, done} !== 2'b11) begin
            n_err++;
            $display("FAIL zero_first: busy,done got %b want 11", {busy, done});
        end
        tick(1);
        @(negedge clock);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL zero_after: busy,done got %b want 00", {busy, done});
        end
        tick(3);
        n_vec++;
        if (rd_addr_q.size() + beat_data_q.size() != 0 || done_cyc_q.size() != 1) begin
            n_err++;
            $display("FAIL zero_activity: reads %0d beats %0d dones %0d want 0 0 1",
                     rd_addr_q.size(), beat_data_q.size(), done_cyc_q.size());
        end
    endtask

    task automatic test_restart_ignored();
        int s;
        int s2;
        clear_logs();
        pulse_start(6'd20, 7'd5, s);
        tick(1);
        pulse_start(6'd40, 7'd2, s2);
        wait_done("restart", 40);
        expect_transfer("restart", 6'd20, 5);
    endtask

    task automatic test_full_length();
        int s;
        clear_logs();
        pulse_start(6'd17, 7'd64, s);
        wait_done("full", 200);
        expect_transfer("full", 6'd17, 64);
        n_vec++;
        if (rd_addr_q.size() != 64 || rd_addr_q[63] !== 6'd16) begin
            n_err++;
            $display("FAIL full_final_addr: got %0d want 16",
                     (rd_addr_q.size() > 0) ? rd_addr_q[rd_addr_q.size() - 1] : 6'd0);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        clear_logs();
        pulse_start(6'd30, 7'd6, s);
        for (int i = 0; i < 20 && beat_data_q.size() < 2; i++) tick(1);
        n_vec++;
        if (beat_data_q.size() < 2) begin
            n_err++;
            $display("FAIL rstmid_beats: got %0d beats want 2 before reset", beat_data_q.size());
        end
        reset = 1'b1;
        tick(1);
        check_idle_outputs("rstmid_outputs");
        reset = 1'b0;
        clear_logs();
        tick(6);
        n_vec++;
        if (done_cyc_q.size() + beat_data_q.size() + rd_addr_q.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_quiet: dones %0d beats %0d reads %0d want 0 0 0",
                     done_cyc_q.size(), beat_data_q.size(), rd_addr_q.size());
        end
        clear_logs();
        pulse_start(6'd3, 7'd2, s);
        wait_done("rstmid_new", 30);
        expect_transfer("rstmid_new", 6'd3, 2);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_length();
        test_restart_ignored();
        test_full_length();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
